// File: rtl/ibex_simd_addsub_pipe.sv
// Pipelined packed-SIMD add/sub (wrap / saturate / halve) with valid/ready on both sides.
// Optional sticky overflow register enabled by defining IBEX_SIMD_OV_STICKY_EN.
module ibex_simd_addsub_pipe #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [1:0]      lane_w_i,
  input  logic [1:0]      mode_i,
  input  logic            sub_i,
  input  logic            signed_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            ov_o,
  output logic            ov_sticky_o,
  input  logic            ov_clr_i
);

  localparam int NB = XLEN / 8;

  logic [1:0]      wsel_s;
  logic [1:0]      mode_s;
  logic [XLEN-1:0] sum_lo_s;
  logic [NB-1:0]   sum_hi_s;

  logic [XLEN-1:0] fin_lo_s;
  logic [NB-1:0]   fin_hi_s;
  logic [1:0]      fin_w_s;
  logic [1:0]      fin_mode_s;
  logic            fin_sub_s;
  logic            fin_sgn_s;
  logic [XLEN-1:0] fin_res_s;
  logic            fin_ov_s;

  logic            in_valid_s;
  logic            out_adv_s;
  logic            valid_q;
  logic [XLEN-1:0] result_q;
  logic            ov_q;

  // 64b lanes fall back to 32b on an RV32 datapath; reserved mode behaves as WRAP.
  assign wsel_s = ((XLEN == 32) && (lane_w_i == 2'b11)) ? 2'b10 : lane_w_i;
  assign mode_s = (mode_i == 2'b11) ? 2'b00 : mode_i;

  // Each lane result is kept as W low bits plus the extra (W+1)th bit in a per-lane vector.
  for (genvar gw = 0; gw < 4; gw++) begin : g_sum
    localparam int W  = 8 << gw;
    localparam int NL = XLEN / W;
    logic [XLEN-1:0] lo_s;
    logic [NB-1:0]   hi_s;
    if (W <= XLEN) begin : g_on
      // Per-lane W+1 bit add/sub; the extension bit isolates carries to the lane.
      always_comb begin
        logic [W:0] ea_v;
        logic [W:0] eb_v;
        logic [W:0] r_v;
        lo_s = '0;
        hi_s = '0;
        ea_v = '0;
        eb_v = '0;
        r_v  = '0;
        for (int i = 0; i < NL; i++) begin
          ea_v = {signed_i & a_i[W*i+W-1], a_i[W*i +: W]};
          eb_v = {signed_i & b_i[W*i+W-1], b_i[W*i +: W]};
          if (sub_i) begin
            r_v = ea_v - eb_v;
          end else begin
            r_v = ea_v + eb_v;
          end
          lo_s[W*i +: W] = r_v[W-1:0];
          hi_s[i]        = r_v[W];
        end
      end
    end else begin : g_off
      assign lo_s = '0;
      assign hi_s = '0;
    end
  end

  // Select the lane-sum set for the requested width.
  always_comb begin
    case (wsel_s)
      2'b00:   begin sum_lo_s = g_sum[0].lo_s; sum_hi_s = g_sum[0].hi_s; end
      2'b01:   begin sum_lo_s = g_sum[1].lo_s; sum_hi_s = g_sum[1].hi_s; end
      2'b10:   begin sum_lo_s = g_sum[2].lo_s; sum_hi_s = g_sum[2].hi_s; end
      2'b11:   begin sum_lo_s = g_sum[3].lo_s; sum_hi_s = g_sum[3].hi_s; end
      default: begin sum_lo_s = g_sum[0].lo_s; sum_hi_s = g_sum[0].hi_s; end
    endcase
  end

  for (genvar gw = 0; gw < 4; gw++) begin : g_fin
    localparam int W  = 8 << gw;
    localparam int NL = XLEN / W;
    logic [XLEN-1:0] res_s;
    logic            ov_s;
    if (W <= XLEN) begin : g_on
      // Clamp (SAT), halve (HALF) or truncate (WRAP) each lane sum.
      always_comb begin
        logic [W-1:0] lo_v;
        logic [W-1:0] res_v;
        logic         h_v;
        res_s = '0;
        ov_s  = 1'b0;
        lo_v  = '0;
        res_v = '0;
        h_v   = 1'b0;
        for (int i = 0; i < NL; i++) begin
          lo_v = fin_lo_s[W*i +: W];
          h_v  = fin_hi_s[i];
          case (fin_mode_s)
            2'b01: begin
              if (fin_sgn_s) begin
                if (h_v != lo_v[W-1]) begin
                  ov_s  = 1'b1;
                  res_v = h_v ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                end else begin
                  res_v = lo_v;
                end
              end else begin
                if (h_v) begin
                  ov_s  = 1'b1;
                  res_v = fin_sub_s ? {W{1'b0}} : {W{1'b1}};
                end else begin
                  res_v = lo_v;
                end
              end
            end
            2'b10:   res_v = {h_v, lo_v[W-1:1]};
            default: res_v = lo_v;
          endcase
          res_s[W*i +: W] = res_v;
        end
      end
    end else begin : g_off
      assign res_s = '0;
      assign ov_s  = 1'b0;
    end
  end

  // Select the finished result for the width travelling with the op.
  always_comb begin
    case (fin_w_s)
      2'b00:   begin fin_res_s = g_fin[0].res_s; fin_ov_s = g_fin[0].ov_s; end
      2'b01:   begin fin_res_s = g_fin[1].res_s; fin_ov_s = g_fin[1].ov_s; end
      2'b10:   begin fin_res_s = g_fin[2].res_s; fin_ov_s = g_fin[2].ov_s; end
      2'b11:   begin fin_res_s = g_fin[3].res_s; fin_ov_s = g_fin[3].ov_s; end
      default: begin fin_res_s = g_fin[0].res_s; fin_ov_s = g_fin[0].ov_s; end
    endcase
  end

  assign out_adv_s = !valid_q || ready_i;

  if (NUM_STAGES == 2) begin : g_two
    logic            v1_q;
    logic [XLEN-1:0] lo_q;
    logic [NB-1:0]   hi_q;
    logic [1:0]      w_q;
    logic [1:0]      mode_q;
    logic            sub_q;
    logic            sgn_q;

    // First stage holds raw lane sums and the controls needed to finish them.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        v1_q   <= 1'b0;
        lo_q   <= '0;
        hi_q   <= '0;
        w_q    <= 2'b00;
        mode_q <= 2'b00;
        sub_q  <= 1'b0;
        sgn_q  <= 1'b0;
      end else if (ready_o) begin
        v1_q <= valid_i;
        if (valid_i) begin
          lo_q   <= sum_lo_s;
          hi_q   <= sum_hi_s;
          w_q    <= wsel_s;
          mode_q <= mode_s;
          sub_q  <= sub_i;
          sgn_q  <= signed_i;
        end
      end
    end

    assign fin_lo_s   = lo_q;
    assign fin_hi_s   = hi_q;
    assign fin_w_s    = w_q;
    assign fin_mode_s = mode_q;
    assign fin_sub_s  = sub_q;
    assign fin_sgn_s  = sgn_q;
    assign in_valid_s = v1_q;
    assign ready_o    = !v1_q || out_adv_s;
  end else begin : g_one
    assign fin_lo_s   = sum_lo_s;
    assign fin_hi_s   = sum_hi_s;
    assign fin_w_s    = wsel_s;
    assign fin_mode_s = mode_s;
    assign fin_sub_s  = sub_i;
    assign fin_sgn_s  = signed_i;
    assign in_valid_s = valid_i;
    assign ready_o    = out_adv_s;
  end

  // Output stage: loads only when empty or retiring, so results hold under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      ov_q     <= 1'b0;
    end else if (out_adv_s) begin
      valid_q <= in_valid_s;
      if (in_valid_s) begin
        result_q <= fin_res_s;
        ov_q     <= fin_ov_s;
      end
    end
  end

  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign ov_o     = ov_q;

`ifdef IBEX_SIMD_OV_STICKY_EN
  logic ov_sticky_q;

  // A saturating retire wins over a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ov_sticky_q <= 1'b0;
    end else if (valid_q && ready_i && ov_q) begin
      ov_sticky_q <= 1'b1;
    end else if (ov_clr_i) begin
      ov_sticky_q <= 1'b0;
    end
  end

  assign ov_sticky_o = ov_sticky_q;
`else
  logic unused_ov_clr_s;
  assign unused_ov_clr_s = ov_clr_i;
  assign ov_sticky_o     = 1'b0;
`endif

endmodule
